// File: rtl/instr_decoder.sv
// instr_decoder: multi-cycle instruction decoder front end.
//   Accepts one 16-bit instruction in IDLE and walks
//   DECODE -> READ -> EXEC -> WB -> IDLE, one state per cycle.
//   It produces register-bank addresses, the ALU op/immediate and a one-cycle
//   write strobe carrying the registered ALU result.
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : codop 11-15 set a sticky `illegal` flag (cleared only by rst).
//   undefined : codop 11-15 behave as NOPs and `illegal` is tied low.
// In both builds codop 11-15 never write and never disturb the decoded outputs.
module instr_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] alu_result,
  output logic [4:0]  reg_a_addr,
  output logic [4:0]  reg_b_addr,
  output logic [4:0]  reg_c_addr,
  output logic [4:0]  codop,
  output logic [15:0] imm,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] instr_q;
  logic [3:0]  op_q;
  logic        accept;
  logic        op_reg_form;
  logic        op_imm_form;
  logic        op_bad;

  // The opcode comes from the latched copy, so input changes after the
  // accept edge cannot reach the instruction in flight.
  assign op_q        = instr_q[15:12];
  assign op_reg_form = (op_q <= 4'd5);
  assign op_imm_form = (op_q >= 4'd6) && (op_q <= 4'd10);
  assign op_bad      = (op_q >= 4'd11);
  assign accept      = instr_valid && (state == IDLE);

  // State register; reset aborts whatever is in flight, including WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: only IDLE waits, every other state lasts one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_valid) state_nxt = DECODE;
      DECODE:  state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic decoded straight from the state register, so rst clears
  // the handshake and the strobe in the same instant it forces IDLE.
  always_comb begin
    instr_ready = (state == IDLE);
    busy        = (state != IDLE);
    wr_en       = (state == WB) && !op_bad;
  end

  // Instruction latch: captured only on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_q <= '0;
    else if (accept) instr_q <= instr;
  end

  // Decoded outputs, registered in DECODE and held until the next DECODE.
  // Bad opcodes leave the previous decode untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      codop      <= '0;
      reg_a_addr <= '0;
      reg_b_addr <= '0;
      reg_c_addr <= '0;
      imm        <= '0;
    end else if (state == DECODE) begin
      if (op_reg_form) begin
        codop      <= {1'b0, op_q};
        reg_c_addr <= {1'b0, instr_q[11:8]};
        reg_a_addr <= {1'b0, instr_q[7:4]};
        reg_b_addr <= {1'b0, instr_q[3:0]};
        imm        <= '0;
      end else if (op_imm_form) begin
        codop      <= {1'b0, op_q};
        reg_c_addr <= {1'b0, instr_q[11:8]};
        reg_a_addr <= '0;
        reg_b_addr <= {1'b0, instr_q[3:0]};
        imm        <= {12'd0, instr_q[7:4]};
      end
    end
  end

  // Write data: ALU output captured on the EXEC->WB edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wr_data <= '0;
    else if (state == EXEC) wr_data <= alu_result;
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag: set when a bad opcode is decoded, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           illegal <= 1'b0;
    else if (state == DECODE && op_bad) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: the driver pushes the expected write
// (edge, data, decoded fields) per instruction; a monitor pops on every wr_en.
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic [15:0] alu_result = '0;
  logic        instr_ready;
  logic [4:0]  reg_a_addr, reg_b_addr, reg_c_addr, codop;
  logic [15:0] imm, wr_data;
  logic        wr_en, busy, illegal;

  instr_decoder dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_result(alu_result),
    .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr), .reg_c_addr(reg_c_addr),
    .codop(codop), .imm(imm), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [15:0] data;
    logic [4:0]  op, a, b, c;
    logic [15:0] imm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_t0 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wr_en) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_en_unexpected: got wr_en=1 data %0h expected no write (edge %0d)",
                 wr_data, cyc + 1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_edge",  cyc + 1,    e.edge_n);
        chk("wr_data",  wr_data,    e.data);
        chk("codop",    codop,      e.op);
        chk("reg_a",    reg_a_addr, e.a);
        chk("reg_b",    reg_b_addr, e.b);
        chk("reg_c",    reg_c_addr, e.c);
        chk("imm",      imm,        e.imm);
      end
    end
  end

  // Offer one instruction, scramble instr while in flight, and return at the
  // negedge where the decoder is back in IDLE (instr_valid left high).
  task automatic send(input logic [15:0] ins, input logic [15:0] alu, input bit wr,
                      input logic [4:0] op, a, b, c, input logic [15:0] im, input bit b2b);
    int t0;
    int n;
    instr       = ins;
    instr_valid = 1'b1;
    alu_result  = 16'hDEAD;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", instr_ready, 1);
    t0 = cyc + 1;
    if (b2b) chk("b2b_accept_edge", t0, last_t0 + 5);
    last_t0 = t0;
    if (wr) q.push_back('{t0 + 4, alu, op, a, b, c, im});
    @(negedge clk);              // DECODE
    instr = ~ins;
    chk("busy_decode", {instr_ready, busy}, 2'b01);
    @(negedge clk);              // READ
    instr = ins ^ 16'h5A5A;
    chk("busy_read", {instr_ready, busy}, 2'b01);
    @(negedge clk);              // EXEC
    alu_result = alu;
    chk("busy_exec", {instr_ready, busy}, 2'b01);
    @(negedge clk);              // WB
    alu_result = 16'hBEEF;
    instr      = 16'h0FFF;
    chk("busy_wb", {instr_ready, busy}, 2'b01);
    @(negedge clk);              // IDLE again
    chk("ready_after_wb", {instr_ready, busy}, 2'b10);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, instr_ready, 1);
    chk({nm, "_busy"},  busy,        0);
    chk({nm, "_wr_en"}, wr_en,       0);
    chk({nm, "_wr_data"}, wr_data,   0);
    chk({nm, "_addrs"}, {reg_a_addr, reg_b_addr, reg_c_addr}, 0);
    chk({nm, "_codop"}, codop,       0);
    chk({nm, "_imm"},   imm,         0);
    chk({nm, "_illegal"}, illegal,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back register and immediate forms with instr_valid held high.
    send(16'h0312, 16'h00AB, 1, 5'd0,  5'd1, 5'd2, 5'd3,  16'h0000, 0);
    send(16'h75F4, 16'h1234, 1, 5'd7,  5'd0, 5'd4, 5'd5,  16'h000F, 1);
    send(16'h5ABC, 16'hFFFF, 1, 5'd5,  5'hB, 5'hC, 5'hA,  16'h0000, 1);
    send(16'hA0E1, 16'h8001, 1, 5'd10, 5'd0, 5'd1, 5'd0,  16'h000E, 1);
    send(16'h6FFF, 16'h0000, 1, 5'd6,  5'd0, 5'hF, 5'hF,  16'h000F, 1);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", {instr_ready, busy, wr_en}, 3'b100);

    // Bad opcode: no write, decoded outputs keep the 6FFF values.
    send(16'hC123, 16'h7777, 0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 0);
    instr_valid = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_flag", illegal, 1);
`else
    chk("illegal_flag", illegal, 0);
`endif
    chk("bad_keeps_op",   codop, 5'd6);
    chk("bad_keeps_addr", {reg_a_addr, reg_b_addr, reg_c_addr}, {5'd0, 5'hF, 5'hF});
    chk("bad_keeps_imm",  imm,   16'h000F);

    // Reset pulsed during EXEC aborts the write.
    @(negedge clk);
    instr = 16'h1234;
    instr_valid = 1'b1;
    @(negedge clk);              // DECODE
    instr_valid = 1'b0;
    alu_result = 16'h4242;
    @(negedge clk);              // READ
    @(negedge clk);              // EXEC
    chk("pre_abort_decode", {codop, reg_c_addr, reg_a_addr, reg_b_addr},
        {5'd1, 5'd2, 5'd3, 5'd4});
    rst = 1'b1;
    #1 chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("after_abort_idle", {instr_ready, busy}, 2'b10);

    // Next instruction after the abort goes through normally.
    send(16'h2345, 16'h5A5A, 1, 5'd2, 5'd4, 5'd5, 5'd3, 16'h0000, 0);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
